alu_arbiter: RTL and testbench

Shares the single combinational ALU (ports a, b, sel, f, zero, less) between NREQ requesters, e.g. the execute stage and the branch/address unit. The block accepts requests over valid/ready handshakes, picks one requester round-robin, and drives the chosen operands into the ALU from registers. It captures the ALU result and returns it to the owning requester over a valid/ready response channel. It sits between the issue logic and the existing ALU instance. The ALU itself stays outside this block.

---
 rtl/alu_arbiter_pkg.sv | 26 ++
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu_arbiter_rr_pick.sv | 30 +++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU op codes, legality check and FSM states.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SLL  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SRL  = 4'd5,
    OP_SUB  = 4'd8,
    OP_SLTU = 4'd10,
    OP_SRA  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic alu_op_legal(input logic [3:0] sel);
    return sel inside {OP_ADD, OP_SLL, OP_SLT, OP_SRL, OP_SUB, OP_SLTU, OP_SRA};
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshakes and the ALU port bundle seen by the arbiter.
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;
  logic [NREQ*4-1:0]    req_sel;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [XLEN-1:0]      rsp_f;
  logic                 rsp_zero;
  logic                 rsp_less;
  logic                 rsp_err;
  logic [XLEN-1:0]      alu_a;
  logic [XLEN-1:0]      alu_b;
  logic [3:0]           alu_sel;
  logic [XLEN-1:0]      alu_f;
  logic                 alu_zero;
  logic                 alu_less;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready, alu_f, alu_zero, alu_less,
    input  req_ready, rsp_valid, rsp_f, rsp_zero, rsp_less, rsp_err, alu_a, alu_b, alu_sel
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready, alu_f, alu_zero, alu_less,
    output req_ready, rsp_valid, rsp_f, rsp_zero, rsp_less, rsp_err, alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            found
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NREQ requesters, round-robin,
// one operation in flight at a time (IDLE -> EXEC -> RESP).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = XLEN_DEF
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state, next_state;
  logic [IW-1:0]   ptr, gnt_idx, pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic            pick_found;
  logic            accept, rsp_done;
  logic [XLEN-1:0] op_a, op_b;
  logic [3:0]      op_sel;
  logic            op_ok;
  logic [XLEN-1:0] res_f;
  logic            res_zero, res_less, res_err;
  logic [3:0]      pick_sel;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign pick_sel = bus.req_sel[pick_idx*4 +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // req_ready is masked by rst_n so every output reads 0 while reset is held.
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    rsp_done      = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          accept        = 1'b1;
          bus.req_ready = pick_onehot & {NREQ{rst_n}};
          next_state    = EXEC;
        end
      end
      EXEC: next_state = RESP;
      RESP: begin
        bus.rsp_valid[gnt_idx] = 1'b1;
        if (bus.rsp_ready[gnt_idx]) begin
          rsp_done   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Illegal ops never reach the ALU; their response is forced to 0 with err set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      gnt_idx  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_sel   <= OP_ADD;
      op_ok    <= 1'b0;
      res_f    <= '0;
      res_zero <= 1'b0;
      res_less <= 1'b0;
      res_err  <= 1'b0;
    end else begin
      if (accept) begin
        gnt_idx <= pick_idx;
        op_a    <= bus.req_a[pick_idx*XLEN +: XLEN];
        op_b    <= bus.req_b[pick_idx*XLEN +: XLEN];
        op_sel  <= pick_sel;
        op_ok   <= alu_op_legal(pick_sel);
      end
      if (state == EXEC) begin
        res_f    <= op_ok ? bus.alu_f : '0;
        res_zero <= op_ok ? bus.alu_zero : 1'b0;
        res_less <= op_ok ? bus.alu_less : 1'b0;
        res_err  <= !op_ok;
      end
      if (rsp_done) begin
        ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign bus.alu_a    = (state == EXEC && op_ok) ? op_a : '0;
  assign bus.alu_b    = (state == EXEC && op_ok) ? op_b : '0;
  assign bus.alu_sel  = (state == EXEC && op_ok) ? op_sel : OP_ADD;
  assign bus.rsp_f    = res_f;
  assign bus.rsp_zero = res_zero;
  assign bus.rsp_less = res_less;
  assign bus.rsp_err  = res_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grant order, latency and results.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0] f;
    logic        zero;
    logic        less;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  alu_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails = 0;

  logic [NREQ-1:0] vld, rrdy, refill;
  logic [31:0]     ra [NREQ];
  logic [31:0]     rb [NREQ];
  logic [3:0]      rs [NREQ];
  bit              randomMode = 0;

  bit          pending = 0;
  int          owner = 0, age = 0, ptr = 0;
  logic [31:0] ea, eb;
  logic [3:0]  esel;
  res_t        eres;
  int          grantLog[$];

  res_t            obs;
  logic [NREQ-1:0] obsRspV;
  res_t            aluOut;

  function automatic bit isLegal(input logic [3:0] s);
    return s inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd8, 4'd10, 4'd13};
  endfunction

  // Behaviour of the external ALU the arbiter is wired to.
  function automatic res_t aluCalc(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    res_t r;
    r.err  = 1'b0;
    r.less = (s == 4'd10) ? (a < b) : ($signed(a) < $signed(b));
    case (s)
      4'd0:    r.f = a + b;
      4'd1:    r.f = a << b[4:0];
      4'd2:    r.f = {31'b0, $signed(a) < $signed(b)};
      4'd5:    r.f = a >> b[4:0];
      4'd8:    r.f = a - b;
      4'd10:   r.f = {31'b0, a < b};
      4'd13:   r.f = $signed(a) >>> b[4:0];
      default: r.f = '0;
    endcase
    r.zero = (r.f == 32'd0);
    return r;
  endfunction

  function automatic res_t expectOf(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    res_t r;
    if (!isLegal(s)) r = '{f: 32'd0, zero: 1'b0, less: 1'b0, err: 1'b1};
    else             r = aluCalc(a, b, s);
    return r;
  endfunction

  always_comb begin
    aluOut       = aluCalc(bus.alu_a, bus.alu_b, bus.alu_sel);
    bus.alu_f    = aluOut.f;
    bus.alu_zero = aluOut.zero;
    bus.alu_less = aluOut.less;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic setOp(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    ra[i] = a;
    rb[i] = b;
    rs[i] = s;
  endtask

  task automatic newOp(input int i);
    logic [3:0] s;
    logic [31:0] a, b;
    if ($urandom_range(7) == 0) begin
      do s = 4'($urandom_range(15)); while (isLegal(s));
    end else begin
      case ($urandom_range(6))
        0: s = 4'd0;  1: s = 4'd1;  2: s = 4'd2;  3: s = 4'd5;
        4: s = 4'd8;  5: s = 4'd10; default: s = 4'd13;
      endcase
    end
    a = $urandom;
    case ($urandom_range(3))
      0:       b = a;
      1:       b = 32'($urandom_range(40));
      default: b = $urandom;
    endcase
    setOp(i, a, b, s);
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, then
  // advance the reference model at the rising edge.
  task automatic applyStimulus();
    int g;
    logic [NREQ-1:0] expReady, expRspV;
    logic [31:0] expA, expB;
    logic [3:0] expS;
    bit inExec, inResp;
    @(negedge clk);
    if (randomMode) begin
      for (int i = 0; i < NREQ; i++)
        if (!vld[i] && $urandom_range(1) == 1) begin
          newOp(i);
          vld[i] = 1'b1;
        end
      rrdy = NREQ'($urandom);
    end
    bus.req_valid = vld;
    bus.rsp_ready = rrdy;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*32 +: 32] = ra[i];
      bus.req_b[i*32 +: 32] = rb[i];
      bus.req_sel[i*4 +: 4] = rs[i];
    end
    #1;
    g = -1;
    if (!pending)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && vld[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    inExec  = pending && age == 0;
    inResp  = pending && age >= 1;
    expRspV = '0;
    if (inResp) expRspV[owner] = 1'b1;
    expA = (inExec && isLegal(esel)) ? ea : 32'd0;
    expB = (inExec && isLegal(esel)) ? eb : 32'd0;
    expS = (inExec && isLegal(esel)) ? esel : 4'd0;
    checkOutput("req_ready", bus.req_ready, expReady);
    checkOutput("rsp_valid", bus.rsp_valid, expRspV);
    checkOutput("alu_a", bus.alu_a, expA);
    checkOutput("alu_b", bus.alu_b, expB);
    checkOutput("alu_sel", bus.alu_sel, expS);
    obs     = '{f: bus.rsp_f, zero: bus.rsp_zero, less: bus.rsp_less, err: bus.rsp_err};
    obsRspV = bus.rsp_valid;
    if (inResp) checkOutput("rsp_data", obs, eres);
    @(posedge clk);
    if (g >= 0) begin
      pending = 1;
      owner   = g;
      age     = 0;
      ea      = ra[g];
      eb      = rb[g];
      esel    = rs[g];
      eres    = expectOf(ra[g], rb[g], rs[g]);
      grantLog.push_back(g);
      if (refill[g]) newOp(g);
      else           vld[g] = 1'b0;
    end else if (pending) begin
      if (age >= 1 && rrdy[owner]) begin
        pending = 0;
        ptr     = (owner + 1) % NREQ;
      end else begin
        age++;
      end
    end
  endtask

  task automatic waitResp(input string tag, input int idx, input res_t want);
    bit seen = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      applyStimulus();
      if (obsRspV[idx]) seen = 1;
    end
    checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
    if (seen) checkOutput({tag, "_rsp"}, obs, want);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_ready"}, bus.req_ready, '0);
    checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, '0);
    checkOutput({tag, "_alu"}, {bus.alu_a, bus.alu_b, bus.alu_sel}, '0);
    checkOutput({tag, "_rsp"}, {bus.rsp_f, bus.rsp_zero, bus.rsp_less, bus.rsp_err}, '0);
  endtask

  initial begin
    int sz;
    vld = '0; rrdy = '1; refill = '0;
    for (int i = 0; i < NREQ; i++) setOp(i, 32'd0, 32'd0, 4'd0);
    bus.req_valid = '0; bus.rsp_ready = '1;
    bus.req_a = '0; bus.req_b = '0; bus.req_sel = '0;
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    $display("[TB] ADD on requester 0");
    setOp(0, 32'd5, 32'd7, 4'd0); vld = 2'b01;
    waitResp("add", 0, '{f: 32'd12, zero: 1'b0, less: 1'b1, err: 1'b0});

    $display("[TB] SUB/SLT/SLTU on requester 1");
    setOp(1, 32'h1234, 32'h1234, 4'd8); vld = 2'b10;
    waitResp("sub", 1, '{f: 32'd0, zero: 1'b1, less: 1'b0, err: 1'b0});
    setOp(1, 32'hFFFF_FFFF, 32'd1, 4'd2); vld = 2'b10;
    waitResp("slt", 1, '{f: 32'd1, zero: 1'b0, less: 1'b1, err: 1'b0});
    setOp(1, 32'hFFFF_FFFF, 32'd1, 4'd10); vld = 2'b10;
    waitResp("sltu", 1, '{f: 32'd0, zero: 1'b1, less: 1'b0, err: 1'b0});

    $display("[TB] both requesters continuously valid");
    newOp(0); newOp(1); vld = 2'b11; refill = 2'b11;
    grantLog.delete();
    repeat (13) applyStimulus();
    sz = grantLog.size();
    checkOutput("alt_count", 64'(sz >= 4), 64'd1);
    if (sz >= 4) checkOutput("alt_order", {16'(grantLog[0]), 16'(grantLog[1]), 16'(grantLog[2]), 16'(grantLog[3])},
                             {16'd0, 16'd1, 16'd0, 16'd1});
    refill = '0;
    repeat (10) applyStimulus();

    $display("[TB] response back-pressure on requester 0");
    setOp(0, 32'hDEAD_0000, 32'd16, 4'd5); vld = 2'b01; rrdy = 2'b10;
    applyStimulus();
    setOp(1, 32'd3, 32'd4, 4'd0); vld[1] = 1'b1;
    sz = grantLog.size();
    repeat (7) applyStimulus();
    checkOutput("hold_no_grant", 64'(grantLog.size()), 64'(sz));
    rrdy = 2'b11;
    repeat (8) applyStimulus();

    $display("[TB] illegal op code");
    setOp(0, 32'd9, 32'd9, 4'd3); vld = 2'b01;
    waitResp("illegal", 0, '{f: 32'd0, zero: 1'b0, less: 1'b0, err: 1'b1});

    $display("[TB] randomized traffic");
    randomMode = 1;
    repeat (400) applyStimulus();
    randomMode = 0; rrdy = '1; vld = '0;
    repeat (6) applyStimulus();

    $display("[TB] reset during EXEC");
    setOp(1, 32'd100, 32'd1, 4'd8); vld = 2'b10;
    sz = grantLog.size();
    for (int c = 0; c < 6 && grantLog.size() == sz; c++) applyStimulus();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    checkAllZero("async_rst");
    pending = 0; ptr = 0; age = 0; vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    setOp(0, 32'd1, 32'd2, 4'd0); setOp(1, 32'd3, 32'd4, 4'd0);
    vld = 2'b11;
    grantLog.delete();
    applyStimulus();
    checkOutput("post_rst_grant", 64'((grantLog.size() > 0) ? grantLog[0] : 99), 64'd0);
    vld = '0;
    repeat (8) applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
